// File: rtl/omega8_pkg.sv
// Shared definitions for the omega8 decode/execute stage: opcodes, instruction
// field positions, FSM state encoding and opcode classification helpers.
package omega8_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  function automatic logic writes_rd(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_MOV, OP_LDI, OP_SHL, OP_SHR: writes_rd = 1'b1;
      default:                        writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic updates_flags(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_CMP: updates_flags = 1'b1;
      default:                updates_flags = 1'b0;
    endcase
  endfunction

  // Opcodes 11..14 are the only unassigned encodings.
  function automatic logic is_illegal(input logic [3:0] op);
    is_illegal = (op >= 4'hB) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/omega8_alu.sv
// Combinational omega8 ALU: computes the result and the carry/zero/negative
// flags for one instruction from the two register operands and the immediate.
module omega8_alu
  import omega8_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm,
  output logic [7:0] result,
  output logic       c,
  output logic       z,
  output logic       n
);

  logic [8:0] wide;

  // Add/subtract run on 9 bits so bit 8 is the carry or the borrow.
  always_comb begin
    wide   = 9'd0;
    result = 8'd0;
    c      = 1'b0;
    case (opcode)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[7:0];
        c      = wide[8];
      end
      OP_SUB, OP_CMP: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[7:0];
        c      = wide[8];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = a;
      OP_LDI: result = imm;
      OP_SHL: begin
        result = {a[6:0], 1'b0};
        c      = a[7];
      end
      OP_SHR: begin
        result = {1'b0, a[7:1]};
        c      = a[0];
      end
      default: result = 8'd0;
    endcase
    z = (result == 8'd0);
    n = result[7];
  end

endmodule

// File: rtl/exec_sequencer.sv
// omega8 decode/execute sequencer: runs each instruction through a fixed
// IDLE -> READ -> EXEC -> WB sequence around a dual-read, single-write regfile.
module exec_sequencer
  import omega8_pkg::*;
#(
  parameter bit ILLEGAL_HALTS = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_instr,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  output logic [2:0]  o_rf_r_address1,
  output logic [2:0]  o_rf_r_address2,
  output logic        o_rf_read,
  input  logic [7:0]  i_rf_data1,
  input  logic [7:0]  i_rf_data2,
  output logic [2:0]  o_rf_w_address,
  output logic [7:0]  o_rf_data,
  output logic        o_rf_write,
  output logic        o_flag_z,
  output logic        o_flag_c,
  output logic        o_flag_n,
  output logic        o_halted,
  output logic        o_illegal
);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] instr_q;
  logic [7:0]  result_q;
  logic [2:0]  rd_q;
  logic        illegal_q;
  logic [3:0]  op_q;
  logic [7:0]  alu_result;
  logic        alu_c;
  logic        alu_z;
  logic        alu_n;

  assign op_q = instr_q[OPC_HI:OPC_LO];

  omega8_alu u_alu (
    .opcode (op_q),
    .a      (i_rf_data1),
    .b      (i_rf_data2),
    .imm    (instr_q[IMM_HI:IMM_LO]),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z),
    .n      (alu_n)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Everything architectural commits at the EXEC edge, so a reset before then
  // leaves no trace of the aborted instruction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      instr_q   <= 16'd0;
      result_q  <= 8'd0;
      rd_q      <= 3'd0;
      o_flag_z  <= 1'b0;
      o_flag_c  <= 1'b0;
      o_flag_n  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (state_q == ST_IDLE && i_instr_valid) instr_q <= i_instr;
      if (state_q == ST_EXEC) begin
        illegal_q <= is_illegal(op_q);
        if (writes_rd(op_q)) begin
          result_q <= alu_result;
          rd_q     <= instr_q[RD_HI:RD_LO];
        end
        if (updates_flags(op_q)) begin
          o_flag_z <= alu_z;
          o_flag_c <= alu_c;
          o_flag_n <= alu_n;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    o_instr_ready = 1'b0;
    o_rf_read     = 1'b0;
    o_rf_write    = 1'b0;
    o_halted      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_instr_ready = 1'b1;
        if (i_instr_valid) state_d = ST_READ;
      end
      ST_READ: begin
        o_rf_read = 1'b1;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        if (op_q == OP_HALT || (ILLEGAL_HALTS && is_illegal(op_q)))
          state_d = ST_HALT;
        else
          state_d = ST_WB;
      end
      ST_WB: begin
        o_rf_write = writes_rd(op_q);
        state_d    = ST_IDLE;
      end
      ST_HALT: begin
        o_halted = 1'b1;
        state_d  = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_rf_r_address1 = instr_q[RS1_HI:RS1_LO];
  assign o_rf_r_address2 = instr_q[RS2_HI:RS2_LO];
  assign o_rf_w_address  = rd_q;
  assign o_rf_data       = result_q;
  assign o_illegal       = illegal_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: directed instructions push expected
// write-back/flag results; a monitor checks each completed instruction.
module tb_exec_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] i_instr = 16'd0;
  logic        i_instr_valid = 1'b0;
  logic        o_instr_ready;
  logic [2:0]  o_rf_r_address1;
  logic [2:0]  o_rf_r_address2;
  logic        o_rf_read;
  logic [7:0]  i_rf_data1 = 8'd0;
  logic [7:0]  i_rf_data2 = 8'd0;
  logic [2:0]  o_rf_w_address;
  logic [7:0]  o_rf_data;
  logic        o_rf_write;
  logic        o_flag_z;
  logic        o_flag_c;
  logic        o_flag_n;
  logic        o_halted;
  logic        o_illegal;

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [2:0] znc;
    logic       ill;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] regs [8];
  int         n_vec = 0;
  int         n_err = 0;
  int         total_writes = 0;

  exec_sequencer #(.ILLEGAL_HALTS(1'b0)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_instr         (i_instr),
    .i_instr_valid   (i_instr_valid),
    .o_instr_ready   (o_instr_ready),
    .o_rf_r_address1 (o_rf_r_address1),
    .o_rf_r_address2 (o_rf_r_address2),
    .o_rf_read       (o_rf_read),
    .i_rf_data1      (i_rf_data1),
    .i_rf_data2      (i_rf_data2),
    .o_rf_w_address  (o_rf_w_address),
    .o_rf_data       (o_rf_data),
    .o_rf_write      (o_rf_write),
    .o_flag_z        (o_flag_z),
    .o_flag_c        (o_flag_c),
    .o_flag_n        (o_flag_n),
    .o_halted        (o_halted),
    .o_illegal       (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  // Register file with one-cycle registered read latency.
  initial for (int i = 0; i < 8; i++) regs[i] = 8'd0;
  always @(posedge i_clk) begin
    if (o_rf_read) begin
      i_rf_data1 <= regs[o_rf_r_address1];
      i_rf_data2 <= regs[o_rf_r_address2];
    end
    if (o_rf_write) regs[o_rf_w_address] <= o_rf_data;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic wr, input logic [2:0] addr, input logic [7:0] data,
                              input logic [2:0] znc, input logic ill);
    exp_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.znc = znc; e.ill = ill;
    return e;
  endfunction

  // Monitor: gathers activity while ready is low and scores it when ready returns.
  int         busy_cnt = 0, n_reads = 0, read_cyc = 0, n_writes = 0, write_cyc = 0, n_ill = 0;
  logic [2:0] seen_addr = 3'd0;
  logic [7:0] seen_data = 8'd0;
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst) begin
      busy_cnt = 0; n_reads = 0; n_writes = 0; n_ill = 0;
    end else if (!o_instr_ready) begin
      busy_cnt++;
      if (o_rf_read) begin n_reads++; read_cyc = busy_cnt; end
      if (o_rf_write) begin
        n_writes++; total_writes++; write_cyc = busy_cnt;
        seen_addr = o_rf_w_address; seen_data = o_rf_data;
      end
      if (o_illegal) n_ill++;
    end else if (busy_cnt != 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_instr", 16'(exp_q.size()), 16'd1);
      end else begin
        e = exp_q.pop_front();
        check("busy_cycles", 16'(busy_cnt), 16'd3);
        check("read_count", 16'(n_reads), 16'd1);
        check("read_cycle", 16'(read_cyc), 16'd1);
        check("write_count", 16'(n_writes), {15'd0, e.wr});
        if (e.wr) begin
          check("write_cycle", 16'(write_cyc), 16'd3);
          check("write_addr", {13'd0, seen_addr}, {13'd0, e.addr});
          check("write_data", {8'd0, seen_data}, {8'd0, e.data});
        end
        check("illegal_pulses", 16'(n_ill), {15'd0, e.ill});
        check("flags_znc", {13'd0, o_flag_z, o_flag_c, o_flag_n}, {13'd0, e.znc});
      end
      busy_cnt = 0; n_reads = 0; n_writes = 0; n_ill = 0;
    end
  end

  task automatic applyStimulus(input logic [15:0] instr, input logic push, input exp_t e);
    int waited;
    @(negedge i_clk);
    i_instr = instr;
    i_instr_valid = 1'b1;
    waited = 0;
    while (!o_instr_ready && waited < 20) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_instr_ready) begin
      check("accept_timeout", {15'd0, o_instr_ready}, 16'd1);
      i_instr_valid = 1'b0;
    end else begin
      if (push) exp_q.push_back(e);
      @(posedge i_clk);
      #1 i_instr_valid = 1'b0;
    end
  endtask

  task automatic checkOutput();
    int waited = 0;
    while ((exp_q.size() != 0 || busy_cnt != 0) && waited < 40) begin
      @(negedge i_clk);
      waited++;
    end
    check("drain_timeout", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ready"}, {15'd0, o_instr_ready}, 16'd1);
    check({name, "_read"}, {15'd0, o_rf_read}, 16'd0);
    check({name, "_write"}, {15'd0, o_rf_write}, 16'd0);
    check({name, "_halted"}, {15'd0, o_halted}, 16'd0);
    check({name, "_illegal"}, {15'd0, o_illegal}, 16'd0);
    check({name, "_flags"}, {13'd0, o_flag_z, o_flag_c, o_flag_n}, 16'd0);
  endtask

  initial begin
    exp_t nx;
    int wc;
    nx = mk(1'b0, 3'd0, 8'd0, 3'b000, 1'b0);
    #1;
    check_quiet("reset");
    check("reset_data", {8'd0, o_rf_data}, 16'd0);
    check("reset_waddr", {13'd0, o_rf_w_address}, 16'd0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;

    applyStimulus(16'h727F, 1'b1, mk(1'b1, 3'd1, 8'h7F, 3'b000, 1'b0));
    applyStimulus(16'h7401, 1'b1, mk(1'b1, 3'd2, 8'h01, 3'b000, 1'b0));
    applyStimulus(16'h1650, 1'b1, mk(1'b1, 3'd3, 8'h80, 3'b001, 1'b0));
    applyStimulus(16'h78FF, 1'b1, mk(1'b1, 3'd4, 8'hFF, 3'b001, 1'b0));
    applyStimulus(16'h1B10, 1'b1, mk(1'b1, 3'd5, 8'h00, 3'b110, 1'b0));
    applyStimulus(16'h2C88, 1'b1, mk(1'b1, 3'd6, 8'h82, 3'b011, 1'b0));
    applyStimulus(16'hA048, 1'b1, mk(1'b0, 3'd0, 8'h00, 3'b100, 1'b0));
    checkOutput();
    check("r6_after_cmp", {8'd0, regs[6]}, 16'h0082);

    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("idle_ready", {15'd0, o_instr_ready}, 16'd1);
      check("idle_read", {15'd0, o_rf_read}, 16'd0);
      check("idle_write", {15'd0, o_rf_write}, 16'd0);
    end

    applyStimulus(16'h3E60, 1'b1, mk(1'b1, 3'd7, 8'h7F, 3'b000, 1'b0));
    applyStimulus(16'h5660, 1'b1, mk(1'b1, 3'd3, 8'h80, 3'b001, 1'b0));
    applyStimulus(16'h8A40, 1'b1, mk(1'b1, 3'd5, 8'hFE, 3'b001, 1'b0));
    applyStimulus(16'h9A80, 1'b1, mk(1'b1, 3'd5, 8'h00, 3'b110, 1'b0));
    applyStimulus(16'h0000, 1'b1, mk(1'b0, 3'd0, 8'h00, 3'b110, 1'b0));
    applyStimulus(16'h6100, 1'b1, mk(1'b1, 3'd0, 8'hFF, 3'b110, 1'b0));
    applyStimulus(16'hB000, 1'b1, mk(1'b0, 3'd0, 8'h00, 3'b110, 1'b1));
    applyStimulus(16'h4C88, 1'b1, mk(1'b1, 3'd6, 8'h7F, 3'b000, 1'b0));
    checkOutput();

    applyStimulus(16'hF000, 1'b0, nx);
    repeat (6) @(negedge i_clk);
    check("halt_halted", {15'd0, o_halted}, 16'd1);
    check("halt_ready", {15'd0, o_instr_ready}, 16'd0);
    wc = total_writes;
    i_instr = 16'h7A11;
    i_instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check("halt_ready_hold", {15'd0, o_instr_ready}, 16'd0);
    end
    i_instr_valid = 1'b0;
    check("halt_no_writes", 16'(total_writes - wc), 16'd0);

    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check_quiet("halt_exit");

    applyStimulus(16'h1E50, 1'b0, nx);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check_quiet("abort");
    check("abort_data", {8'd0, o_rf_data}, 16'd0);
    check("abort_waddr", {13'd0, o_rf_w_address}, 16'd0);
    check("abort_raddr1", {13'd0, o_rf_r_address1}, 16'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);
    check("abort_r7_kept", {8'd0, regs[7]}, 16'h007F);
    check_quiet("after_abort");

    applyStimulus(16'h7E55, 1'b1, mk(1'b1, 3'd7, 8'h55, 3'b000, 1'b0));
    checkOutput();
    check("r7_after_ldi", {8'd0, regs[7]}, 16'h0055);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
